// File: rtl/unidad_control.sv
// Instruction sequencer for unidad_procesadora: decodes 16-bit instructions into datapath
// control words, runs the LOAD/STORE memory handshake and implements a conditional skip.
module unidad_control #(
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [15:0] ctrl_word,
   input  logic [3:0]  stateBits,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {StRun, StMemWait, StWb} state_e;

   localparam logic [3:0] OpAluRr = 4'h1;
   localparam logic [3:0] OpAluRk = 4'h2;
   localparam logic [3:0] OpShift = 4'h3;
   localparam logic [3:0] OpLoad  = 4'h4;
   localparam logic [3:0] OpStore = 4'h5;
   localparam logic [3:0] OpSkip  = 4'h6;

   state_e             state_q, state_d;
   logic [15:0]        ctrl_q, ctrl_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               skip_pend_q, skip_pend_d;
   logic               skip_arm_q, skip_arm_d;
   logic [1:0]         skip_bit_q, skip_bit_d;
   logic               skip_byp_q, skip_byp_d;
   logic               alu_pres_q, alu_pres_d;
   logic               alu_d1_q, alu_d1_d;
   logic [3:0]         flag_hold_q, flag_hold_d;
   logic               started_q;

   logic [3:0] op, fn;
   logic [1:0] fa, fb, fd;
   logic       fire, skip_flag, pending;
   logic       unused_rsv;

   assign op = instr[15:12];
   assign fd = instr[11:10];
   assign fa = instr[9:8];
   assign fb = instr[7:6];
   assign fn = instr[5:2];
   assign unused_rsv = ^instr[1:0];

   assign instr_ready = started_q && (state_q == StRun);
   assign busy        = (state_q != StRun);
   assign ctrl_word   = ctrl_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign err         = err_q;
   assign fire        = instr_valid && instr_ready;

   // A SKIP is resolved the cycle after it is taken, when the flags of a directly preceding
   // ALU op are visible on stateBits; older results come from flag_hold.
   assign skip_flag = skip_byp_q ? stateBits[skip_bit_q] : flag_hold_q[skip_bit_q];
   assign pending   = skip_pend_q || (skip_arm_q && skip_flag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ctrl_q      <= 16'h0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         skip_pend_q <= 1'b0;
         skip_arm_q  <= 1'b0;
         skip_bit_q  <= 2'b00;
         skip_byp_q  <= 1'b0;
         alu_pres_q  <= 1'b0;
         alu_d1_q    <= 1'b0;
         flag_hold_q <= 4'h0;
         started_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         skip_pend_q <= skip_pend_d;
         skip_arm_q  <= skip_arm_d;
         skip_bit_q  <= skip_bit_d;
         skip_byp_q  <= skip_byp_d;
         alu_pres_q  <= alu_pres_d;
         alu_d1_q    <= alu_d1_d;
         flag_hold_q <= flag_hold_d;
         started_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      skip_pend_d = pending;
      skip_arm_d  = 1'b0;
      skip_bit_d  = skip_bit_q;
      skip_byp_d  = skip_byp_q;
      alu_pres_d  = 1'b0;
      alu_d1_d    = alu_pres_q;
      flag_hold_d = alu_d1_q ? stateBits : flag_hold_q;

      unique case (state_q)
         StRun: begin
            ctrl_d = 16'h0000;
            if (fire) begin
               if (pending) begin
                  skip_pend_d = 1'b0;
               end else begin
                  case (op)
                     OpAluRr: begin
                        ctrl_d     = {fa, fb, fd, 1'b1, 1'b1, fn, 2'b00, 1'b0, 1'b0};
                        alu_pres_d = 1'b1;
                     end
                     OpAluRk: begin
                        ctrl_d     = {fa, fb, fd, 1'b1, 1'b0, fn, 2'b00, 1'b0, 1'b0};
                        alu_pres_d = 1'b1;
                     end
                     OpShift: begin
                        ctrl_d = {fa, fb, fd, 1'b1, 1'b1, 4'h0, fn[1:0], 1'b1, 1'b0};
                     end
                     OpLoad: begin
                        ctrl_d    = {fa, 2'b00, fd, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b1};
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = StMemWait;
                     end
                     OpStore: begin
                        ctrl_d    = {fa, fb, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0};
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        cnt_d     = '0;
                        state_d   = StMemWait;
                     end
                     OpSkip: begin
                        skip_arm_d = 1'b1;
                        skip_bit_d = fn[1:0];
                        skip_byp_d = alu_pres_q;
                     end
                     default: ;
                  endcase
               end
            end
         end
         StMemWait: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (mem_we_q) begin
                  ctrl_d  = 16'h0000;
                  state_d = StRun;
               end else begin
                  // Write-back cycle: same fields, register write enabled.
                  ctrl_d  = ctrl_q | 16'h0200;
                  state_d = StWb;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = 1'b1;
               ctrl_d    = 16'h0000;
               state_d   = StRun;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWb: begin
            ctrl_d  = 16'h0000;
            state_d = StRun;
         end
         default: begin
            ctrl_d  = 16'h0000;
            state_d = StRun;
         end
      endcase
   end

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: table of single-instruction decodes through a scoreboard queue,
// plus hand-written memory, timeout, skip and reset sequences.
module tb_unidad_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] ctrl_word;
   logic [3:0]  stateBits;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ack;
   logic        err;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic        chk_pend = 1'b0;

   typedef struct {
      logic [15:0] ins;
      logic [15:0] exp;
   } vec_t;

   unidad_control #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .ctrl_word   (ctrl_word),
      .stateBits   (stateBits),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_ack     (mem_ack),
      .err         (err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Drives one instruction for a single accepted transfer; returns on the following negedge.
   task automatic drive(input logic [15:0] ins, input logic [15:0] exp);
      int waited = 0;
      while (!instr_ready && waited < 50) begin
         step();
         waited++;
      end
      if (!instr_ready) begin
         check("ready_timeout", 16'(instr_ready), 16'h1);
      end else begin
         instr       = ins;
         instr_valid = 1'b1;
         exp_q.push_back(exp);
         step();
         instr_valid = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      chk_pend = rst_n && instr_valid && instr_ready;
   end

   initial forever begin
      @(negedge clk);
      if (chk_pend) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 16'h1, 16'h0);
         end else begin
            check("sb_ctrl_word", ctrl_word, exp_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   nreq;
      int   nwe;

      vecs[0] = '{16'h19D0, 16'h7B40};
      vecs[1] = '{16'h29D0, 16'h7A40};
      vecs[2] = '{16'h1E3C, 16'h8FF0};
      vecs[3] = '{16'h39D4, 16'h7B06};
      vecs[4] = '{16'h300C, 16'h030E};
      vecs[5] = '{16'h0FFF, 16'h0000};
      vecs[6] = '{16'hF9D0, 16'h0000};
      vecs[7] = '{16'h8FFF, 16'h0000};

      rst_n       = 1'b0;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      stateBits   = 4'h0;
      mem_ack     = 1'b0;
      #12;
      check("rst_ctrl", ctrl_word, 16'h0000);
      check("rst_ready", 16'(instr_ready), 16'h0);
      check("rst_mem_req", 16'(mem_req), 16'h0);
      check("rst_err_busy", {14'h0, err, busy}, 16'h0);
      step();
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 16'(instr_ready), 16'h0);
      step();
      check("ready_after_edge", 16'(instr_ready), 16'h1);

      // Basic ALU op then idle return to NOP
      drive(16'h19D0, 16'h7B40);
      step();
      check("idle_nop", ctrl_word, 16'h0000);

      for (int i = 0; i < 8; i++) drive(vecs[i].ins, vecs[i].exp);
      step();

      // LOAD with ack three cycles later
      drive(16'h4600, 16'h8401);
      check("load_req", {14'h0, mem_req, mem_we}, 16'h0002);
      check("load_ready", {14'h0, instr_ready, busy}, 16'h0001);
      step();
      step();
      check("load_hold", ctrl_word, 16'h8401);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("load_wb", ctrl_word, 16'h8601);
      check("load_wb_req", {14'h0, mem_req, instr_ready}, 16'h0000);
      step();
      check("load_done", {ctrl_word[15:2], instr_ready, busy}, 16'h0002);

      // STORE timing out
      drive(16'h59C0, 16'h7100);
      nreq = 0;
      nwe  = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req) nreq++;
         if (ctrl_word[9]) nwe++;
         if (!mem_req && nreq > 0) break;
         step();
      end
      check("timeout_req_cycles", 16'(nreq), 16'd8);
      check("timeout_no_we", 16'(nwe), 16'd0);
      check("timeout_err", {14'h0, err, instr_ready}, 16'h0003);
      check("timeout_ctrl", ctrl_word, 16'h0000);
      drive(16'h1E3C, 16'h8FF0);
      check("err_sticky", 16'(err), 16'h1);

      // mem_ack outside MEM_WAIT
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      check("stray_ack", {ctrl_word[15:2], mem_req, busy}, 16'h0000);

      // SKIP taken via bypass
      stateBits = 4'b0001;
      drive(16'h19D0, 16'h7B40);
      drive(16'h6000, 16'h0000);
      drive(16'h19D0, 16'h0000);
      drive(16'h1E3C, 16'h8FF0);

      // SKIP not taken
      stateBits = 4'b0000;
      drive(16'h19D0, 16'h7B40);
      drive(16'h6000, 16'h0000);
      drive(16'h19D0, 16'h7B40);

      // Discarded SKIP has no effect
      stateBits = 4'b0001;
      drive(16'h19D0, 16'h7B40);
      drive(16'h6000, 16'h0000);
      drive(16'h6000, 16'h0000);
      drive(16'h19D0, 16'h7B40);

      // SKIP using held flags after an intervening NOP
      drive(16'h19D0, 16'h7B40);
      drive(16'h0000, 16'h0000);
      drive(16'h6000, 16'h0000);
      stateBits = 4'b0000;
      drive(16'h19D0, 16'h0000);
      drive(16'h1E3C, 16'h8FF0);

      // Skipped LOAD makes no memory access
      stateBits = 4'b0001;
      drive(16'h19D0, 16'h7B40);
      drive(16'h6000, 16'h0000);
      drive(16'h4600, 16'h0000);
      check("skip_load_noreq", {14'h0, mem_req, busy}, 16'h0000);

      // Reset in the middle of a LOAD
      drive(16'h4600, 16'h8401);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {14'h0, mem_req, busy}, 16'h0000);
      check("mid_rst_ctrl", ctrl_word, 16'h0000);
      check("mid_rst_err", 16'(err), 16'h0);
      step();
      rst_n = 1'b1;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
      check("post_rst_no_wb", {ctrl_word[15:2], mem_req, busy}, 16'h0000);
      drive(16'h29D0, 16'h7A40);
      step();

      check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
